// File: rtl/l2_pkg.sv
// Shared configuration for the L2 stream fill slice: line geometry, slot count and
// the EA-to-slot mapping used by both the request tagger and the functional reset.
package l2_pkg;

    localparam int unsigned addr_width       = 64;
    localparam int unsigned cache_line       = 128;
    localparam int unsigned cache_line_width = $clog2(cache_line);
    localparam int unsigned l2_ncl           = 256;
    localparam int unsigned l2_ncl_width     = $clog2(l2_ncl);
    localparam int unsigned data_width       = cache_line * 8;

    // Slot index of an EA: the line number modulo the slot count. The result is returned
    // at full address width with the upper bits zeroed, so callers size-cast it.
    function automatic logic [addr_width-1:0] ea_to_slot(
        input logic [addr_width-1:0] ea,
        input int unsigned           line_w = cache_line_width,
        input int unsigned           ncl_w  = l2_ncl_width
    );
        logic [addr_width-1:0] mask;
        mask = (addr_width'(1) << ncl_w) - addr_width'(1);
        return (ea >> line_w) & mask;
    endfunction

endpackage

// File: rtl/l2_stream_fill_if.sv
// Stream-fill bundle: request pass-through to the host, host responses, URAM write
// port and the in-order line-valid back to the stream pointer.
interface l2_stream_fill_if
    import l2_pkg::*;
#(
    parameter int unsigned AddrWidth = addr_width,
    parameter int unsigned TagWidth  = l2_ncl_width,
    parameter int unsigned DataWidth = data_width
);

    logic                 i_set_v;
    logic [AddrWidth-1:0] i_set_ea;

    logic                 i_req_v;
    logic                 i_req_r;
    logic [AddrWidth-1:0] i_req_ea;

    logic                 o_req_v;
    logic                 o_req_r;
    logic [AddrWidth-1:0] o_req_ea;
    logic [TagWidth-1:0]  o_req_tag;

    logic                 i_hrsp_v;
    logic                 i_hrsp_r;
    logic [TagWidth-1:0]  i_hrsp_tag;
    logic [DataWidth-1:0] i_hrsp_d;

    logic                 o_wr_v;
    logic [TagWidth-1:0]  o_wr_addr;
    logic [DataWidth-1:0] o_wr_d;

    logic                 o_rsp_v;
    logic                 o_rsp_r;

    logic                 o_err;

    // Fill block side.
    modport slave (
        input  i_set_v, i_set_ea,
        input  i_req_v, i_req_ea,
        output i_req_r,
        output o_req_v, o_req_ea, o_req_tag,
        input  o_req_r,
        input  i_hrsp_v, i_hrsp_tag, i_hrsp_d,
        output i_hrsp_r,
        output o_wr_v, o_wr_addr, o_wr_d,
        output o_rsp_v,
        input  o_rsp_r,
        output o_err
    );

    // Environment side (stream pointer, host and URAM together).
    modport master (
        output i_set_v, i_set_ea,
        output i_req_v, i_req_ea,
        input  i_req_r,
        input  o_req_v, o_req_ea, o_req_tag,
        output o_req_r,
        output i_hrsp_v, i_hrsp_tag, i_hrsp_d,
        input  i_hrsp_r,
        input  o_wr_v, o_wr_addr, o_wr_d,
        input  o_rsp_v,
        output o_rsp_r,
        input  o_err
    );

endinterface

// File: rtl/l2_fill_bitmap.sv
// Per-slot flag register: one set port, one clear port, a clear-all that overrides
// both, and two independent indexed read ports. Set wins over clear on the same bit.
module l2_fill_bitmap
    import l2_pkg::*;
#(
    parameter  int unsigned Depth    = l2_ncl,
    localparam int unsigned IdxWidth = $clog2(Depth)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_all_i,
    input  logic                set_i,
    input  logic [IdxWidth-1:0] set_idx_i,
    input  logic                clr_i,
    input  logic [IdxWidth-1:0] clr_idx_i,
    input  logic [IdxWidth-1:0] rd_a_idx_i,
    output logic                rd_a_o,
    input  logic [IdxWidth-1:0] rd_b_idx_i,
    output logic                rd_b_o
);

    logic [Depth-1:0] bits_q, bits_d;

    // Next bitmap: clear-all dominates, otherwise apply clear then set.
    always_comb begin
        bits_d = bits_q;
        if (clr_all_i) begin
            bits_d = '0;
        end else begin
            if (clr_i) begin
                bits_d[clr_idx_i] = 1'b0;
            end
            if (set_i) begin
                bits_d[set_idx_i] = 1'b1;
            end
        end
    end

    // Bitmap register with synchronous power-on clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign rd_a_o = bits_q[rd_a_idx_i];
    assign rd_b_o = bits_q[rd_b_idx_i];

endmodule

// File: rtl/l2_stream_fill.sv
// Fill side of one L2 stream slot. Tags host requests with their L2 line slot, writes
// host responses (any order) into the URAM one cycle after acceptance, and returns
// line-valid pulses to the stream pointer strictly in slot order starting at head.
// Optional protocol checking is compiled in with L2_STREAM_FILL_CHK_EN.
module l2_stream_fill
    import l2_pkg::*;
#(
    parameter int unsigned CacheLine = cache_line,
    parameter int unsigned L2Ncl     = l2_ncl
) (
    input  logic            clk,
    input  logic            reset,
    l2_stream_fill_if.slave bus
);

    localparam int unsigned CacheLineWidth = $clog2(CacheLine);
    localparam int unsigned L2NclWidth     = $clog2(L2Ncl);
    localparam int unsigned DataWidth      = CacheLine * 8;

    logic [L2NclWidth-1:0] req_tag;
    logic [L2NclWidth-1:0] set_slot;
    logic [L2NclWidth-1:0] head_q, head_d;

    logic                  wr_v_q, wr_v_d;
    logic [L2NclWidth-1:0] wr_addr_q, wr_addr_d;
    logic [DataWidth-1:0]  wr_d_q, wr_d_d;

    logic                  rsp_v;
    logic                  rsp_fire;
    logic                  done_rsp;

    assign req_tag  = L2NclWidth'(ea_to_slot(bus.i_req_ea, CacheLineWidth, L2NclWidth));
    assign set_slot = L2NclWidth'(ea_to_slot(bus.i_set_ea, CacheLineWidth, L2NclWidth));

    // Request path is a pure pass-through plus the slot tag.
    assign bus.o_req_v   = bus.i_req_v;
    assign bus.i_req_r   = bus.o_req_r;
    assign bus.o_req_ea  = bus.i_req_ea;
    assign bus.o_req_tag = req_tag;

    assign bus.i_hrsp_r = 1'b1;

    // Next write-stage contents: every accepted response becomes exactly one write.
    always_comb begin
        wr_v_d    = bus.i_hrsp_v;
        wr_addr_d = wr_addr_q;
        wr_d_d    = wr_d_q;
        if (bus.i_hrsp_v) begin
            wr_addr_d = bus.i_hrsp_tag;
            wr_d_d    = bus.i_hrsp_d;
        end
    end

    // Write-stage register; address and data are don't-care while the valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_v_q <= 1'b0;
        end else begin
            wr_v_q <= wr_v_d;
        end
        wr_addr_q <= wr_addr_d;
        wr_d_q    <= wr_d_d;
    end

    assign bus.o_wr_v    = wr_v_q;
    assign bus.o_wr_addr = wr_addr_q;
    assign bus.o_wr_d    = wr_d_q;

    // Completed-line flags; the head slot's flag is the in-order line-valid.
    // A same-cycle functional reset discards the response's flag but not its write.
    l2_fill_bitmap #(
        .Depth (L2Ncl)
    ) u_done (
        .clk        (clk),
        .reset      (reset),
        .clr_all_i  (bus.i_set_v),
        .set_i      (bus.i_hrsp_v),
        .set_idx_i  (bus.i_hrsp_tag),
        .clr_i      (rsp_fire),
        .clr_idx_i  (head_q),
        .rd_a_idx_i (head_q),
        .rd_a_o     (rsp_v),
        .rd_b_idx_i (bus.i_hrsp_tag),
        .rd_b_o     (done_rsp)
    );

    assign rsp_fire    = rsp_v & bus.o_rsp_r;
    assign bus.o_rsp_v = rsp_v;

    // Next head: reload from the new stream EA, else advance on each accepted line-valid.
    always_comb begin
        head_d = head_q;
        if (bus.i_set_v) begin
            head_d = set_slot;
        end else if (rsp_fire) begin
            head_d = head_q + L2NclWidth'(1);
        end
    end

    // Head pointer register; wraps naturally since the slot count is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
        end else begin
            head_q <= head_d;
        end
    end

`ifdef L2_STREAM_FILL_CHK_EN
    logic req_fire;
    logic pend_rsp;
    logic pend_req;
    logic viol;
    logic err_q, err_d;

    assign req_fire = bus.i_req_v & bus.o_req_r;

    // Outstanding-request flags, used only to detect protocol violations.
    l2_fill_bitmap #(
        .Depth (L2Ncl)
    ) u_pending (
        .clk        (clk),
        .reset      (reset),
        .clr_all_i  (bus.i_set_v),
        .set_i      (req_fire),
        .set_idx_i  (req_tag),
        .clr_i      (bus.i_hrsp_v),
        .clr_idx_i  (bus.i_hrsp_tag),
        .rd_a_idx_i (bus.i_hrsp_tag),
        .rd_a_o     (pend_rsp),
        .rd_b_idx_i (req_tag),
        .rd_b_o     (pend_req)
    );

    assign viol = (bus.i_hrsp_v & ~pend_rsp)
                | (req_fire & pend_req)
                | (bus.i_hrsp_v & done_rsp);

    // Sticky error: only power-on reset clears it, a functional reset does not.
    always_comb begin
        err_d = err_q | viol;
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.o_err = err_q;
`else
    logic unused_done_rsp;
    assign unused_done_rsp = done_rsp;
    assign bus.o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_l2_stream_fill.sv
// Directed bench for l2_stream_fill with 8 slots of 128-byte lines. A behavioural
// model of slot flags/head/error runs alongside and is compared on every cycle;
// directed sequences additionally pin hand-computed expectations.
module tb_l2_stream_fill;

    localparam int unsigned NCL = 8;
    localparam int unsigned CL  = 128;
    localparam int unsigned AW  = 64;
    localparam int unsigned TW  = 3;
    localparam int unsigned DW  = CL * 8;

`ifdef L2_STREAM_FILL_CHK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    l2_stream_fill_if #(.AddrWidth(AW), .TagWidth(TW), .DataWidth(DW)) bus ();

    l2_stream_fill #(.CacheLine(CL), .L2Ncl(NCL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, want completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got low word %0h, want low word %0h (t=%0t)",
                      name, act[63:0], exp[63:0], $time);
    endtask

    function automatic logic [DW-1:0] pat(input int tag);
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 64; k++) v[k*64 +: 64] = {8'(tag), 8'(k), 48'h5A3C_96E1_0F7B};
        return v;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    bit            m_init = 1'b0;
    bit            m_done [NCL];
    bit            m_pend [NCL];
    int            m_head;
    bit            m_err;
    bit            m_wr_v;
    int            m_wr_addr;
    logic [DW-1:0] m_wr_d;

    always @(negedge clk) begin
        if (reset) begin
            m_init = 1'b1;
            m_head = 0;
            m_err  = 1'b0;
            m_wr_v = 1'b0;
            for (int i = 0; i < NCL; i++) begin
                m_done[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
        end else if (m_init) begin
            bit fire;
            bit rfire;
            bit viol;
            int ntag;
            int rtag;
            check("wr_v", 64'(bus.o_wr_v), 64'(m_wr_v));
            if (m_wr_v) begin
                check("wr_addr", 64'(bus.o_wr_addr), 64'(m_wr_addr));
                check_data("wr_d", bus.o_wr_d, m_wr_d);
            end
            check("rsp_v", 64'(bus.o_rsp_v), 64'(m_done[m_head]));
            check("err", 64'(bus.o_err), 64'(m_err));
            check("req_v_pass", 64'(bus.o_req_v), 64'(bus.i_req_v));
            check("req_r_pass", 64'(bus.i_req_r), 64'(bus.o_req_r));
            check("req_ea_pass", bus.o_req_ea, bus.i_req_ea);
            check("req_tag", 64'(bus.o_req_tag), (bus.i_req_ea / CL) % NCL);
            check("hrsp_r", 64'(bus.i_hrsp_r), 64'd1);

            // Advance the model by the inputs that the next edge will sample.
            fire  = m_done[m_head] && bus.o_rsp_r;
            ntag  = int'(bus.i_hrsp_tag);
            rtag  = int'((bus.i_req_ea / CL) % NCL);
            rfire = bus.i_req_v && bus.o_req_r;
            viol  = (bus.i_hrsp_v && !m_pend[ntag]) || (rfire && m_pend[rtag])
                 || (bus.i_hrsp_v && m_done[ntag]);
            if (ChkEn && viol) m_err = 1'b1;
            m_wr_v    = bus.i_hrsp_v;
            m_wr_addr = ntag;
            m_wr_d    = bus.i_hrsp_d;
            if (bus.i_set_v) begin
                m_head = int'((bus.i_set_ea / CL) % NCL);
                for (int i = 0; i < NCL; i++) begin
                    m_done[i] = 1'b0;
                    m_pend[i] = 1'b0;
                end
            end else begin
                if (fire) begin
                    m_done[m_head] = 1'b0;
                    m_head = (m_head + 1) % NCL;
                end
                if (bus.i_hrsp_v) begin
                    m_done[ntag] = 1'b1;
                    m_pend[ntag] = 1'b0;
                end
                if (rfire) m_pend[rtag] = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.i_set_v  = 1'b0;
        bus.i_req_v  = 1'b0;
        bus.i_hrsp_v = 1'b0;
    endtask

    task automatic do_set(input logic [AW-1:0] ea);
        bus.i_set_v  = 1'b1;
        bus.i_set_ea = ea;
    endtask

    task automatic do_req(input logic [AW-1:0] ea);
        bus.i_req_v  = 1'b1;
        bus.i_req_ea = ea;
    endtask

    task automatic do_rsp(input int tag);
        bus.i_hrsp_v   = 1'b1;
        bus.i_hrsp_tag = TW'(tag);
        bus.i_hrsp_d   = pat(tag);
    endtask

    task automatic req_tagged(input logic [AW-1:0] ea, input int exp_tag);
        clr();
        do_req(ea);
        #1;
        check("lit_req_tag", 64'(bus.o_req_tag), 64'(exp_tag));
        tick();
    endtask

    // ---------------- directed sequences ----------------
    int  t2_tag [5] = '{2, 0, 1, -1, -1};
    bit  t2_exp [5] = '{0, 1, 1, 1, 0};
    int  t3_tag [6] = '{7, 0, 6, -1, -1, -1};
    bit  t3_exp [6] = '{0, 0, 1, 1, 1, 0};

    initial begin
        logic [5:0] drain;
        int         cnt;

        clr();
        bus.i_set_ea   = '0;
        bus.i_req_ea   = '0;
        bus.i_hrsp_tag = '0;
        bus.i_hrsp_d   = '0;
        bus.o_req_r    = 1'b1;
        bus.o_rsp_r    = 1'b1;
        reset          = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("lit_reset_wr_v", 64'(bus.o_wr_v), 64'd0);
        check("lit_reset_rsp_v", 64'(bus.o_rsp_v), 64'd0);
        check("lit_reset_err", 64'(bus.o_err), 64'd0);
        tick();

        // In-order fill.
        clr(); do_set(64'h0); tick();
        for (int i = 0; i < 3; i++) req_tagged(64'(i * 128), i);
        for (int i = 0; i < 3; i++) begin
            clr(); do_rsp(i); tick();
            check("lit_t1_wr_v", 64'(bus.o_wr_v), 64'd1);
            check("lit_t1_wr_addr", 64'(bus.o_wr_addr), 64'(i));
            check_data("lit_t1_wr_d", bus.o_wr_d, pat(i));
            check("lit_t1_rsp_v", 64'(bus.o_rsp_v), 64'd1);
        end
        clr(); tick();
        check("lit_t1_wr_idle", 64'(bus.o_wr_v), 64'd0);
        check("lit_t1_rsp_idle", 64'(bus.o_rsp_v), 64'd0);

        // Out-of-order.
        clr(); do_set(64'h0); tick();
        for (int i = 0; i < 3; i++) req_tagged(64'(i * 128), i);
        for (int k = 0; k < 5; k++) begin
            clr();
            if (t2_tag[k] >= 0) do_rsp(t2_tag[k]);
            tick();
            check("lit_t2_rsp_v", 64'(bus.o_rsp_v), 64'(t2_exp[k]));
        end

        // Wrap: head 6, tags 7, 0, 6.
        clr(); do_set(64'h300); tick();
        req_tagged(64'h380, 7);
        req_tagged(64'h400, 0);
        req_tagged(64'h300, 6);
        for (int k = 0; k < 6; k++) begin
            clr();
            if (t3_tag[k] >= 0) do_rsp(t3_tag[k]);
            tick();
            check("lit_t3_rsp_v", 64'(bus.o_rsp_v), 64'(t3_exp[k]));
        end
        check("lit_t3_model_head", 64'(m_head), 64'd1);
        req_tagged(64'h480, 1);
        clr(); do_rsp(1); tick();
        check("lit_t3_head1_rsp_v", 64'(bus.o_rsp_v), 64'd1);
        clr(); tick();
        check("lit_t3_after_rsp_v", 64'(bus.o_rsp_v), 64'd0);

        // Backpressure: four lines done, stream pointer stalled for five cycles.
        clr(); do_set(64'h0); tick();
        for (int i = 0; i < 4; i++) req_tagged(64'(i * 128), i);
        bus.o_rsp_r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clr(); do_rsp(i); tick();
            check("lit_t4_fill_rsp_v", 64'(bus.o_rsp_v), 64'd1);
        end
        for (int i = 0; i < 5; i++) begin
            clr(); tick();
            check("lit_t4_hold_rsp_v", 64'(bus.o_rsp_v), 64'd1);
        end
        check("lit_t4_model_head", 64'(m_head), 64'd0);
        bus.o_rsp_r = 1'b1;
        cnt   = 0;
        drain = '0;
        for (int i = 0; i < 6; i++) begin
            clr();
            #1;
            drain[i] = bus.o_rsp_v;
            if (bus.o_rsp_v) cnt++;
            tick();
        end
        check("lit_t4_drain_cnt", 64'(cnt), 64'd4);
        check("lit_t4_drain_pattern", 64'(drain), 64'b001111);

        // Functional reset colliding with a response.
        req_tagged(64'h280, 5);
        clr(); do_set(64'h200); do_rsp(5); tick();
        check("lit_t5_wr_v", 64'(bus.o_wr_v), 64'd1);
        check("lit_t5_wr_addr", 64'(bus.o_wr_addr), 64'd5);
        check_data("lit_t5_wr_d", bus.o_wr_d, pat(5));
        check("lit_t5_rsp_v", 64'(bus.o_rsp_v), 64'd0);
        clr(); tick();
        check("lit_t5_rsp_v_later", 64'(bus.o_rsp_v), 64'd0);
        check("lit_t5_model_head", 64'(m_head), 64'd4);
        req_tagged(64'h200, 4);
        clr(); do_rsp(4); tick();
        check("lit_t5_head4_rsp_v", 64'(bus.o_rsp_v), 64'd1);
        clr(); tick();
        check("lit_t5_slot5_empty", 64'(bus.o_rsp_v), 64'd0);

        // Protocol check: response for a slot never requested.
        check("lit_t6_err_before", 64'(bus.o_err), 64'd0);
        clr(); do_rsp(3); tick();
        check("lit_t6_err_after", 64'(bus.o_err), 64'(ChkEn));
        clr(); do_set(64'h0); tick();
        check("lit_t6_err_sticky", 64'(bus.o_err), 64'(ChkEn));
        clr(); tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
